// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that lends a single accumulating adder
// input (add_din / add_en) to one of NREQ requesters for a whole burst.
// A burst is locked to its owner until the owner flags its last word, hits
// MAX_BURST transfers, or drops its request. Every burst is followed by a
// one-cycle GAP before the next arbitration, and the finished owner becomes
// lowest priority for the next grant.
//
// Handshake: a word of requester i is accepted on a rising edge when
// req_ready[i] and req[i] are both high in the cycle before that edge.
// req_ready is one-hot (or zero) and depends only on state and gnt_id, never
// on req, so there is no combinational path from req to req_ready.
module adder_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 6,
  parameter int MAX_BURST = 16,
  parameter int IDW       = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_din,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      add_din,
  output logic               add_en,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_valid,
  output logic               burst_done,
  output logic               burst_cut
);

  // Beat counter must hold MAX_BURST itself; it is cleared on every grant.
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [BCW-1:0]  beat, beat_nxt;
  logic [DW-1:0]   add_din_nxt;
  logic            add_en_nxt;
  logic [IDW-1:0]  gnt_id_nxt;
  logic            gnt_valid_nxt;
  logic            burst_done_nxt;
  logic            burst_cut_nxt;

  // Arbitration result and signals of the current owner.
  logic            found;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  idx;
  logic            xfer;
  logic            cur_last;
  logic [DW-1:0]   cur_din;
  logic            hit_max;
  logic            burst_end;

  // Round-robin search starting at ptr; NREQ is a power of two so the
  // IDW-bit addition wraps naturally.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Owner-side view: transfer, last flag, data slice and burst-end reasons.
  always_comb begin
    xfer      = req[gnt_id];
    cur_last  = req_last[gnt_id];
    cur_din   = req_din[int'(gnt_id)*DW +: DW];
    hit_max   = xfer && (beat == BCW'(MAX_BURST - 1));
    // Without a transfer the burst is abandoned; otherwise last or max ends it.
    burst_end = !xfer || cur_last || hit_max;
  end

  // Ready is a pure function of state and owner.
  assign req_ready = (state == GRANT) ? (NREQ'(1) << gnt_id) : '0;

  // Next-state and next-output logic of the IDLE/GRANT/GAP controller.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    beat_nxt       = beat;
    add_din_nxt    = add_din;
    add_en_nxt     = 1'b0;
    gnt_id_nxt     = gnt_id;
    gnt_valid_nxt  = gnt_valid;
    burst_done_nxt = 1'b0;
    burst_cut_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_id_nxt    = sel;
          gnt_valid_nxt = 1'b1;
          beat_nxt      = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          add_din_nxt = cur_din;
          add_en_nxt  = 1'b1;
          beat_nxt    = beat + 1'b1;
        end
        if (burst_end) begin
          state_nxt      = GAP;
          gnt_valid_nxt  = 1'b0;
          burst_done_nxt = 1'b1;
          // A word that is both last and the MAX_BURST-th counts as a clean end.
          burst_cut_nxt  = hit_max && !cur_last;
          // Finished owner drops to lowest priority.
          ptr_nxt        = gnt_id + 1'b1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      beat       <= '0;
      add_din    <= '0;
      add_en     <= 1'b0;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      burst_done <= 1'b0;
      burst_cut  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      beat       <= beat_nxt;
      add_din    <= add_din_nxt;
      add_en     <= add_en_nxt;
      gnt_id     <= gnt_id_nxt;
      gnt_valid  <= gnt_valid_nxt;
      burst_done <= burst_done_nxt;
      burst_cut  <= burst_cut_nxt;
    end
  end

endmodule
